instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 127 ++++++++++++
 tb/tb_instr_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - program-memory instruction sequencer that issues words to a processor and waits for done
// Optional watchdog compiled in with `define SEQ_TIMEOUT_EN.

module instr_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  input  logic              done,
  output logic [15:0]       Din,
  output logic              run,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HALT,
    S_ERROR
  } state_t;

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  logic [15:0]       mem [DEPTH];
  logic              can_load;
  logic [ADDR_W-1:0] pc_next;
  logic [15:0]       start_word;
  logic [15:0]       next_word;

  function automatic logic is_halt(input logic [15:0] w);
    return w[15:13] == 3'b111;
  endfunction

  assign can_load = (state == S_IDLE) || (state == S_HALT) || (state == S_ERROR);
  assign busy     = (state == S_ISSUE) || (state == S_WAIT);
  assign halted   = (state == S_HALT);
  assign pc_next  = pc + 1'b1;

  // A write to address 0 on the start edge must be what gets issued first.
  assign start_word = (prog_we && prog_addr == '0) ? prog_data : mem[0];
  assign next_word  = mem[pc_next];

  always_ff @(posedge clock) begin
    if (prog_we && can_load) begin
      mem[prog_addr] <= prog_data;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_cnt;
`else
  assign err = 1'b0;
`endif

  // Din and run are loaded on the edge that enters ISSUE so they are valid for the whole ISSUE cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      pc     <= '0;
      Din    <= '0;
      run    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      err    <= 1'b0;
      wd_cnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_HALT, S_ERROR: begin
          if (start) begin
            state <= S_ISSUE;
            pc    <= '0;
            Din   <= start_word;
            run   <= !is_halt(start_word);
`ifdef SEQ_TIMEOUT_EN
            err   <= 1'b0;
`endif
          end
        end
        S_ISSUE: begin
          run <= 1'b0;
          if (is_halt(Din)) begin
            state <= S_HALT;
          end else begin
            state <= S_WAIT;
`ifdef SEQ_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (done) begin
            if (pc == LAST_ADDR) begin
              state <= S_HALT;
            end else begin
              state <= S_ISSUE;
              pc    <= pc_next;
              Din   <= next_word;
              run   <= !is_halt(next_word);
            end
`ifdef SEQ_TIMEOUT_EN
          end else if (wd_cnt == WD_LAST) begin
            state <= S_ERROR;
            err   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer with a done-responder model
// Watchdog cases are built only with `define SEQ_TIMEOUT_EN.

module tb_instr_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [15:0] prog_data;
  logic        done;
  logic [15:0] Din;
  logic        run;
  logic [4:0]  pc;
  logic        busy;
  logic        halted;
  logic        err;

  logic        rsp_done;
  logic        man_done;
  logic        resp_en;
  int          lat;
  int          total;
  int          bad;
  logic [15:0] exp_q[$];

  assign done = rsp_done | man_done;

  instr_sequencer #(.ADDR_W(5), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .done(done),
    .Din(Din), .run(run), .pc(pc), .busy(busy), .halted(halted), .err(err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Processor model: done is returned lat cycles after the run cycle.
  initial begin
    int cd;
    cd = -1;
    rsp_done = 1'b0;
    forever begin
      @(negedge clock);
      rsp_done = 1'b0;
      if (!reset) begin
        cd = -1;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            rsp_done = 1'b1;
            cd = -1;
          end
        end
        if (run && resp_en) cd = lat;
      end
    end
  end

  // Monitor: every run pulse must match the next expected instruction word.
  initial begin
    forever begin
      @(negedge clock);
      if (reset && run) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_run", {16'h0, Din}, 32'hDEAD_0000);
        end else begin
          chk("run_din", {16'h0, Din}, {16'h0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    @(negedge clock);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clock);
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_halted(input int max, input string nm);
    int n;
    n = 0;
    while (!halted && n < max) begin
      @(negedge clock);
      n++;
    end
    if (!halted) chk({nm, "_halt_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_run(input int max, input string nm);
    int n;
    n = 0;
    while (!run && n < max) begin
      @(negedge clock);
      n++;
    end
    if (!run) chk({nm, "_run_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic push_prog4();
    for (int i = 0; i < 4; i++) exp_q.push_back(16'h0100 + 16'(i));
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    man_done = 1'b0; resp_en = 1'b1; lat = 3;
    #1;
    chk("rst_run", {31'h0, run}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_halted", {31'h0, halted}, 32'd0);
    chk("rst_err", {31'h0, err}, 32'd0);
    chk("rst_pc", {27'h0, pc}, 32'd0);
    chk("rst_din", {16'h0, Din}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Two-word program ending in a halt word.
    wr(5'd0, 16'h1002);
    wr(5'd1, 16'hE000);
    exp_q.push_back(16'h1002);
    lat = 3;
    pulse_start();
    wait_halted(50, "t32");
    chk("t32_halted", {31'h0, halted}, 32'd1);
    chk("t32_pc", {27'h0, pc}, 32'd1);
    chk("t32_din_hold", {16'h0, Din}, 32'h0000_E000);
    chk("t32_busy", {31'h0, busy}, 32'd0);

    // Full memory with no halt word: stop at the last address.
    for (int i = 0; i < 32; i++) wr(5'(i), 16'h4001);
    for (int i = 0; i < 32; i++) exp_q.push_back(16'h4001);
    lat = 2;
    pulse_start();
    wait_halted(200, "t33");
    chk("t33_pc", {27'h0, pc}, 32'd31);
    chk("t33_q_empty", exp_q.size(), 32'd0);
    @(negedge clock);
    man_done = 1'b1;
    @(negedge clock);
    man_done = 1'b0;
    repeat (3) @(negedge clock);
    chk("t33_done_ignored_pc", {27'h0, pc}, 32'd31);
    chk("t33_still_halted", {31'h0, halted}, 32'd1);

    // Distinct words verify address ordering; a write+start while busy must be ignored.
    for (int i = 0; i < 4; i++) wr(5'(i), 16'h0100 + 16'(i));
    wr(5'd4, 16'hE123);
    push_prog4();
    lat = 2;
    pulse_start();
    wait_run(20, "t37");
    @(negedge clock);
    prog_we = 1'b1; prog_addr = 5'd0; prog_data = 16'hFFFF; start = 1'b1;
    @(negedge clock);
    prog_we = 1'b0; start = 1'b0;
    wait_halted(100, "t37");
    chk("t37_pc", {27'h0, pc}, 32'd4);
    chk("t37_din", {16'h0, Din}, 32'h0000_E123);
    push_prog4();
    pulse_start();
    wait_halted(100, "t37b");
    chk("t37b_q_empty", exp_q.size(), 32'd0);

    // Reset two cycles into WAIT aborts the instruction.
    resp_en = 1'b0;
    exp_q.push_back(16'h0100);
    pulse_start();
    wait_run(20, "t36");
    repeat (3) @(negedge clock);
    chk("t36_busy_before", {31'h0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("t36_run", {31'h0, run}, 32'd0);
    chk("t36_busy", {31'h0, busy}, 32'd0);
    chk("t36_pc", {27'h0, pc}, 32'd0);
    chk("t36_din", {16'h0, Din}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    man_done = 1'b1;
    @(negedge clock);
    man_done = 1'b0;
    repeat (3) @(negedge clock);
    chk("t36_post_busy", {31'h0, busy}, 32'd0);
    chk("t36_post_pc", {27'h0, pc}, 32'd0);
    chk("t36_post_halted", {31'h0, halted}, 32'd0);
    resp_en = 1'b1;
    push_prog4();
    pulse_start();
    wait_halted(100, "t36b");
    chk("t36b_pc", {27'h0, pc}, 32'd4);

`ifdef SEQ_TIMEOUT_EN
    // Watchdog fires on the 15th WAIT edge with no done.
    wr(5'd0, 16'h2207);
    wr(5'd1, 16'hE000);
    resp_en = 1'b0;
    exp_q.push_back(16'h2207);
    pulse_start();
    wait_run(20, "t34");
    repeat (15) @(posedge clock);
    #1;
    chk("t34_err_early", {31'h0, err}, 32'd0);
    @(posedge clock);
    #1;
    chk("t34_err", {31'h0, err}, 32'd1);
    chk("t34_busy", {31'h0, busy}, 32'd0);
    chk("t34_halted", {31'h0, halted}, 32'd0);
    resp_en = 1'b1;
    lat = 2;
    exp_q.push_back(16'h2207);
    pulse_start();
    chk("t34_err_clear", {31'h0, err}, 32'd0);
    wait_halted(50, "t34b");
    chk("t34b_pc", {27'h0, pc}, 32'd1);

    // done on the 15th WAIT cycle beats the watchdog.
    wr(5'd1, 16'h3333);
    wr(5'd2, 16'hE000);
    exp_q.push_back(16'h2207);
    exp_q.push_back(16'h3333);
    lat = 15;
    pulse_start();
    wait_halted(100, "t35");
    chk("t35_err", {31'h0, err}, 32'd0);
    chk("t35_pc", {27'h0, pc}, 32'd2);
`endif

    repeat (3) @(negedge clock);
    chk("final_q_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
